imm_decode_stage: RTL
=====================

// Module: imm_decode_stage
// PURPOSE
//  Decode-stage controller that sequences the SEXT immediate generator between fetch and execute.
//  Classifies each incoming instruction by opcode and drives sext_op to an internal SEXT instance, fed with inst[31:7].
//  Registers {inst, pc, imm, sext_op} into a 2-entry (main + skid) valid/ready buffer.
//  Fetch and execute can stall independently without losing or duplicating instructions.
// PARAMETERS
//  XLEN     32   datapath width of inst/pc/imm (only 32 supported)
//  RST_PC   0    value driven on out_pc_o during and after reset
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  flush_i      in   1     synchronous flush (branch redirect); drops all buffered entries
//  in_valid_i   in   1     fetch presents inst_i/pc_i
//  in_ready_o   in   1     (out) stage can accept; registered, equals !skid_valid
//  inst_i       in   32    raw instruction
//  pc_i         in   32    instruction PC
//  out_valid_o  out  1     main entry valid
//  out_ready_i  in   1     execute accepts main entry
//  out_inst_o   out  32    buffered instruction
//  out_pc_o     out  32    buffered PC
//  imm_o        out  32    sign-extended immediate of buffered instruction
//  sext_op_o    out  3     immediate class: 000 I, 001 S, 010 B, 011 U, 100 J, 111 none
//  illegal_o    out  1     buffered opcode unrecognised (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): main/skid valid=0, out_valid_o=0, in_ready_o=1, out_inst_o=0,
//    out_pc_o=RST_PC, imm_o=0, sext_op_o=3'b111, illegal_o=0.
//  - Opcode map (inst[6:0]):
//    - I type: 0010011, 0000011, 1100111, 1110011
//    - S type: 0100011
//    - B type: 1100011
//    - U type: 0110111, 0010111
//    - J type: 1101111
//    - none (imm=0): 0110011, 0001111
//    - illegal: all other opcodes
//  - imm is computed combinationally from inst_i at accept time and stored; never recomputed from output regs.
//  - Accept: in_valid_i & in_ready_o. Latency 1 cycle: data accepted on edge N is on outputs after edge N.
//  - Output handshake: out_valid_o & out_ready_i retires main. Outputs hold stable while out_valid_o=1 and !out_ready_i.
//  - Buffer states: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
//    - EMPTY + accept -> ONE.
//    - ONE + accept + retire -> ONE (main reloaded).
//    - ONE + accept, no retire -> FULL (skid captures).
//    - ONE + retire, no accept -> EMPTY.
//    - FULL + retire -> ONE (skid moves to main).
//    - FULL never accepts, since in_ready_o=0.
//  - Ordering: strictly FIFO; skid always older than any new accept.
//  - flush_i=1: next state EMPTY regardless of handshakes; an accept in the flush cycle is discarded.
//    in_ready_o=1 the cycle after. flush_i has priority over in_valid_i and out_ready_i.
//  - Async reset mid-transfer: buffered entries dropped immediately, outputs to reset values.
//  - Data regs of an invalid entry are don't-care, except the reset values listed above.
// CONFIGURATION
//  IMM_ILLEGAL_CHK_EN defined:
//    - illegal opcodes set illegal_o=1 with the entry, and imm_o=0, sext_op_o=3'b111.
//    - The entry still flows through the handshake normally.
//  IMM_ILLEGAL_CHK_EN undefined:
//    - illegal_o tied 0; unrecognised opcodes are treated as I type (sext_op 000).
// TESTING
//  - Stream (out_ready_i=1):
//    - 32'hFFF00093 -> next cycle imm_o=32'hFFFFFFFF, sext_op_o=000.
//    - 32'h00112623 -> imm_o=32'h0000000C, sext_op_o=001.
//  - Branch/jump:
//    - 32'hFE000EE3 -> imm_o=32'hFFFFFFFC, sext_op_o=010.
//    - 32'hFF9FF0EF -> imm_o=32'hFFFFFFF8, sext_op_o=100.
//  - U/R: 32'h123450B7 -> imm_o=32'h12345000, sext_op_o=011; 32'h002081B3 -> imm_o=0, sext_op_o=111.
//  - Backpressure: hold out_ready_i=0 and push A, B. Required:
//    - in_ready_o=0 after B; outputs stay A.
//    - Release -> A, then B, on consecutive cycles; in_ready_o=1 again one cycle after A retires.
//  - Flush while FULL with simultaneous accept: out_valid_o=0 next cycle, in_ready_o=1, nothing emitted.
//  - Reset asserted mid-stream: outputs immediately at reset values; opcode 7'b1111111 gives
//    illegal_o=1 with IMM_ILLEGAL_CHK_EN, and illegal_o=0, sext_op_o=000 without.

Source files
------------

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - decode stage: opcode classify, SEXT immediate, 2-entry skid buffer
// Optional build macro IMM_ILLEGAL_CHK_EN flags unrecognised opcodes via illegal_o.
module imm_sext (
    input  logic [24:0] inst_hi_i,
    input  logic [2:0]  sext_op_i,
    output logic [31:0] imm_o
);
    // inst_hi_i[k] is inst[k+7]
    always_comb begin
        imm_o = '0;
        case (sext_op_i)
            3'b000:  imm_o = {{20{inst_hi_i[24]}}, inst_hi_i[24:13]};
            3'b001:  imm_o = {{20{inst_hi_i[24]}}, inst_hi_i[24:18], inst_hi_i[4:0]};
            3'b010:  imm_o = {{20{inst_hi_i[24]}}, inst_hi_i[0], inst_hi_i[23:18],
                              inst_hi_i[4:1], 1'b0};
            3'b011:  imm_o = {inst_hi_i[24:5], 12'b0};
            3'b100:  imm_o = {{12{inst_hi_i[24]}}, inst_hi_i[12:5], inst_hi_i[13],
                              inst_hi_i[23:14], 1'b0};
            default: imm_o = '0;
        endcase
    end
endmodule

module imm_decode_stage #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_inst_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      sext_op_o,
    output logic            illegal_o
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      sext_op;
        logic            illegal;
    } entry_t;

    localparam entry_t RST_ENTRY = '{inst: '0, pc: RST_PC, imm: '0, sext_op: 3'b111, illegal: 1'b0};

    state_t      state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    entry_t      new_entry;
    logic [2:0]  dec_op;
    logic        dec_ill;
    logic [31:0] sext_imm;
    logic        accept;
    logic        retire;

    always_comb begin
        dec_op  = 3'b000;
        dec_ill = 1'b0;
        case (inst_i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_op = 3'b000;
            7'b0100011:                                     dec_op = 3'b001;
            7'b1100011:                                     dec_op = 3'b010;
            7'b0110111, 7'b0010111:                         dec_op = 3'b011;
            7'b1101111:                                     dec_op = 3'b100;
            7'b0110011, 7'b0001111:                         dec_op = 3'b111;
            default: begin
`ifdef IMM_ILLEGAL_CHK_EN
                dec_op  = 3'b111;
                dec_ill = 1'b1;
`else
                dec_op  = 3'b000;
                dec_ill = 1'b0;
`endif
            end
        endcase
    end

    imm_sext u_sext (
        .inst_hi_i (inst_i[31:7]),
        .sext_op_i (dec_op),
        .imm_o     (sext_imm)
    );

    always_comb begin
        new_entry         = RST_ENTRY;
        new_entry.inst    = inst_i;
        new_entry.pc      = pc_i;
        new_entry.imm     = sext_imm;
        new_entry.sext_op = dec_op;
        new_entry.illegal = dec_ill;
    end

    // The skid entry is always older than anything accepted alongside it.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = in_valid_i & (state_q != FULL);
        retire  = out_ready_i & (state_q != EMPTY);
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = new_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        main_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = FULL;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= RST_ENTRY;
            skid_q  <= RST_ENTRY;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_inst_o  = main_q.inst;
    assign out_pc_o    = main_q.pc;
    assign imm_o       = main_q.imm;
    assign sext_op_o   = main_q.sext_op;
    assign illegal_o   = main_q.illegal;
endmodule
